// File: rtl/spi_arbiter.sv
// Round-robin sequencer sharing one 16-bit SPI master between three requesters.
// Latency: req in IDLE -> spi_wrt next cycle; spi_done -> rsp_vld next cycle; GAP_CYC+2 dead cycles between transactions.
// Backpressure: requesters hold req/cmd until their rsp_vld; a stalled master is released by the watchdog with rsp_err.
module spi_arbiter #(
    parameter int GAP_CYC = 8,
    parameter int TIMEOUT = 2047
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    input  logic [15:0] cmd2,
    output logic [2:0]  gnt,
    output logic [2:0]  rsp_vld,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_WAIT_DONE,
        S_RESP,
        S_GAP
    } state_t;

    localparam logic [10:0] TIMEOUT_W = 11'(TIMEOUT);
    localparam logic [7:0]  GAP_LOAD  = 8'(GAP_CYC - 1);

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [15:0] spi_cmd_q, spi_cmd_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        err_q, err_d;
    logic [10:0] wdog_q, wdog_d;
    logic [7:0]  gap_q, gap_d;

    logic [1:0]  sel_idx;
    logic [2:0]  cand;
    logic [10:0] wdog_inc;

    // Rotating priority search: walk down from the farthest candidate so the
    // one closest to ptr overwrites the others.
    always_comb begin
        sel_idx = ptr_q;
        cand    = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (req[cand[1:0]]) begin
                sel_idx = cand[1:0];
            end
        end
    end

    assign wdog_inc = wdog_q + 11'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= 2'd0;
            gnt_q      <= 3'b000;
            spi_cmd_q  <= 16'h0000;
            rsp_data_q <= 16'h0000;
            err_q      <= 1'b0;
            wdog_q     <= 11'd0;
            gap_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            spi_cmd_q  <= spi_cmd_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
            wdog_q     <= wdog_d;
            gap_q      <= gap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        spi_cmd_d  = spi_cmd_q;
        rsp_data_d = rsp_data_q;
        err_d      = err_q;
        wdog_d     = wdog_q;
        gap_d      = gap_q;
        case (state_q)
            S_IDLE: begin
                if (req != 3'b000) begin
                    gnt_d = 3'b001 << sel_idx;
                    case (sel_idx)
                        2'd1:    spi_cmd_d = cmd1;
                        2'd2:    spi_cmd_d = cmd2;
                        default: spi_cmd_d = cmd0;
                    endcase
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_SETTLE;
            end
            // The master's done still reflects the previous transaction here.
            S_SETTLE: begin
                wdog_d  = 11'd0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                wdog_d = wdog_inc;
                if (spi_done) begin
                    rsp_data_d = spi_rd_data;
                    err_d      = 1'b0;
                    state_d    = S_RESP;
                end else if (wdog_inc == TIMEOUT_W) begin
                    rsp_data_d = 16'h0000;
                    err_d      = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (gnt_q[0]) begin
                    ptr_d = 2'd1;
                end else if (gnt_q[1]) begin
                    ptr_d = 2'd2;
                end else begin
                    ptr_d = 2'd0;
                end
                gap_d   = GAP_LOAD;
                gnt_d   = 3'b000;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        spi_wrt = 1'b0;
        rsp_vld = 3'b000;
        rsp_err = 1'b0;
        if (state_q == S_LAUNCH) begin
            spi_wrt = 1'b1;
        end
        if (state_q == S_RESP) begin
            rsp_vld = gnt_q;
            rsp_err = err_q;
        end
    end

    assign gnt      = gnt_q;
    assign spi_cmd  = spi_cmd_q;
    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: stub SPI master plus requester model, scoreboard of launches and responses.
module tb_spi_arbiter;

    localparam int GAP_CYC = 8;
    localparam int TIMEOUT = 2047;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [15:0] cmd0, cmd1, cmd2;
    logic [2:0]  gnt;
    logic [2:0]  rsp_vld;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd_data;

    spi_arbiter #(.GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .cmd0        (cmd0),
        .cmd1        (cmd1),
        .cmd2        (cmd2),
        .gnt         (gnt),
        .rsp_vld     (rsp_vld),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .spi_wrt     (spi_wrt),
        .spi_cmd     (spi_cmd),
        .spi_done    (spi_done),
        .spi_rd_data (spi_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  gnt;
        logic [15:0] cmd;
    } launch_t;

    typedef struct {
        logic [2:0]  vld;
        logic [15:0] data;
        logic        err;
    } rsp_t;

    launch_t exp_launch[$];
    rsp_t    exp_rsp[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_wrt = 0;
    int n_rsp = 0;
    int wrt_cyc = 0;
    int rsp_cyc = 0;
    bit have_rsp = 0;
    logic [15:0] last_cmd = 16'h0000;

    int          remaining[3];
    int          stub_delay = 0;
    logic [15:0] stub_data[3];
    bit          stale_mode = 0;
    bit          exact_gap  = 0;
    bit          scramble   = 0;
    bit          pending    = 0;
    int          cnt        = 0;
    int          drop_in    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int idx_of(input logic [2:0] g);
        if (g == 3'b010) return 1;
        if (g == 3'b100) return 2;
        return 0;
    endfunction

    // Monitor and stub master share one process so their order within a cycle is fixed.
    always @(negedge clk) begin
        if (!rst_n) begin
            pending  = 0;
            drop_in  = 0;
            spi_done = 1'b0;
            have_rsp = 0;
        end else begin
            if (rsp_vld !== 3'b000) begin
                n_rsp++;
                n_cmp++;
                if ($countones(rsp_vld) != 1) begin
                    n_bad++;
                    $display("FAIL rsp_onehot: rsp_vld=%b is not one-hot", rsp_vld);
                end
                n_cmp++;
                if (exp_rsp.size() == 0) begin
                    n_bad++;
                    $display("FAIL rsp_unexpected: rsp_vld=%b data=%h at cycle %0d", rsp_vld, rsp_data, cyc);
                end else begin
                    rsp_t e;
                    e = exp_rsp.pop_front();
                    n_cmp++;
                    if (rsp_vld !== e.vld) begin
                        n_bad++;
                        $display("FAIL rsp_vld: got %b want %b", rsp_vld, e.vld);
                    end
                    n_cmp++;
                    if (rsp_data !== e.data) begin
                        n_bad++;
                        $display("FAIL rsp_data: got %h want %h", rsp_data, e.data);
                    end
                    n_cmp++;
                    if (rsp_err !== e.err) begin
                        n_bad++;
                        $display("FAIL rsp_err: got %b want %b", rsp_err, e.err);
                    end
                end
                n_cmp++;
                if (spi_cmd !== last_cmd) begin
                    n_bad++;
                    $display("FAIL spi_cmd_hold: got %h want %h", spi_cmd, last_cmd);
                end
                for (int i = 0; i < 3; i++) begin
                    if (rsp_vld[i] && remaining[i] > 0) remaining[i]--;
                end
                rsp_cyc  = cyc;
                have_rsp = 1;
            end
            if (spi_wrt === 1'b1) begin
                n_wrt++;
                wrt_cyc = cyc;
                n_cmp++;
                if (exp_launch.size() == 0) begin
                    n_bad++;
                    $display("FAIL wrt_unexpected: gnt=%b cmd=%h at cycle %0d", gnt, spi_cmd, cyc);
                end else begin
                    launch_t l;
                    l = exp_launch.pop_front();
                    n_cmp++;
                    if (gnt !== l.gnt) begin
                        n_bad++;
                        $display("FAIL launch_gnt: got %b want %b", gnt, l.gnt);
                    end
                    n_cmp++;
                    if (spi_cmd !== l.cmd) begin
                        n_bad++;
                        $display("FAIL launch_cmd: got %h want %h", spi_cmd, l.cmd);
                    end
                end
                last_cmd = spi_cmd;
                if (have_rsp) begin
                    n_cmp++;
                    if (exact_gap ? (cyc - rsp_cyc != GAP_CYC + 2) : (cyc - rsp_cyc < GAP_CYC + 2)) begin
                        n_bad++;
                        $display("FAIL launch_gap: got %0d cycles want %s%0d", cyc - rsp_cyc,
                                 exact_gap ? "" : ">=", GAP_CYC + 2);
                    end
                end
                if (scramble) begin
                    case (idx_of(gnt))
                        1:       cmd1 = ~cmd1;
                        2:       cmd2 = ~cmd2;
                        default: cmd0 = ~cmd0;
                    endcase
                end
                pending = 1;
                cnt     = stub_delay;
                if (stale_mode) drop_in = 2;
                else            spi_done = 1'b0;
            end else begin
                if (drop_in > 0) begin
                    drop_in--;
                    if (drop_in == 0) spi_done = 1'b0;
                end
                if (pending && stub_delay != 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        spi_done    = 1'b1;
                        spi_rd_data = stub_data[idx_of(gnt)];
                        pending     = 0;
                    end
                end
            end
        end
        req = {remaining[2] > 0, remaining[1] > 0, remaining[0] > 0};
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) remaining[i] = 0;
        req        = 3'b000;
        stale_mode = 0;
        exact_gap  = 0;
        scramble   = 0;
        stub_delay = 0;
        spi_rd_data = 16'h0000;
        repeat (3) @(negedge clk);
        exp_launch.delete();
        exp_rsp.delete();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int target, input int budget, input string name);
        int k = 0;
        while (n_rsp < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_rsp < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_wait: got %0d responses want %0d within %0d cycles", name, n_rsp, target, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        cmd0  = 16'h0000; cmd1 = 16'h0000; cmd2 = 16'h0000;
        spi_done = 1'b0;
        spi_rd_data = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (gnt !== 3'b000)      begin n_bad++; $display("FAIL reset_gnt: got %b want 000", gnt); end
        n_cmp++; if (rsp_vld !== 3'b000)  begin n_bad++; $display("FAIL reset_rsp_vld: got %b want 000", rsp_vld); end
        n_cmp++; if (rsp_err !== 1'b0)    begin n_bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        n_cmp++; if (rsp_data !== 16'h0)  begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
        n_cmp++; if (spi_wrt !== 1'b0)    begin n_bad++; $display("FAIL reset_spi_wrt: got %b want 0", spi_wrt); end
        n_cmp++; if (spi_cmd !== 16'h0)   begin n_bad++; $display("FAIL reset_spi_cmd: got %h want 0000", spi_cmd); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        n_cmp++; if (spi_wrt !== 1'b0 || n_wrt != 0) begin n_bad++; $display("FAIL idle_no_req: got %0d writes want 0", n_wrt); end
    endtask

    task automatic test_single();
        int base_wrt, base_rsp, t0;
        apply_reset();
        stub_delay   = 1100;
        stub_data[1] = 16'h1234;
        cmd1         = 16'hA5C3;
        exp_launch.push_back('{3'b010, 16'hA5C3});
        exp_rsp.push_back('{3'b010, 16'h1234, 1'b0});
        base_wrt = n_wrt;
        base_rsp = n_rsp;
        remaining[1] = 1;
        req = 3'b010;
        t0  = cyc;
        wait_rsp(base_rsp + 1, 1300, "single");
        n_cmp++; if (wrt_cyc != t0 + 1) begin n_bad++; $display("FAIL single_launch_lat: got cycle %0d want %0d", wrt_cyc, t0 + 1); end
        n_cmp++; if (rsp_cyc - wrt_cyc != 1101) begin n_bad++; $display("FAIL single_rsp_lat: got %0d want 1101", rsp_cyc - wrt_cyc); end
        repeat (30) @(negedge clk);
        #1;
        n_cmp++; if (n_wrt - base_wrt != 1) begin n_bad++; $display("FAIL single_wrt_count: got %0d want 1", n_wrt - base_wrt); end
        n_cmp++; if (n_rsp - base_rsp != 1) begin n_bad++; $display("FAIL single_rsp_count: got %0d want 1", n_rsp - base_rsp); end
    endtask

    task automatic test_simultaneous();
        int base_rsp;
        apply_reset();
        stub_delay = 30;
        stub_data[0] = 16'h0A0A; stub_data[1] = 16'h1B1B; stub_data[2] = 16'h2C2C;
        cmd0 = 16'h1000; cmd1 = 16'h2001; cmd2 = 16'h3002;
        scramble = 1;
        exp_launch.push_back('{3'b001, 16'h1000});
        exp_launch.push_back('{3'b010, 16'h2001});
        exp_launch.push_back('{3'b100, 16'h3002});
        exp_rsp.push_back('{3'b001, 16'h0A0A, 1'b0});
        exp_rsp.push_back('{3'b010, 16'h1B1B, 1'b0});
        exp_rsp.push_back('{3'b100, 16'h2C2C, 1'b0});
        base_rsp = n_rsp;
        for (int i = 0; i < 3; i++) remaining[i] = 1;
        req = 3'b111;
        wait_rsp(base_rsp + 3, 400, "simul");
        scramble = 0;
        n_cmp++; if (exp_launch.size() != 0 || exp_rsp.size() != 0) begin
            n_bad++; $display("FAIL simul_drain: got %0d/%0d left want 0/0", exp_launch.size(), exp_rsp.size());
        end
    endtask

    task automatic test_back_to_back();
        int base_rsp;
        logic [2:0] g;
        apply_reset();
        stub_delay = 12;
        stub_data[0] = 16'h5100; stub_data[2] = 16'h5322;
        cmd0 = 16'hC0C0; cmd2 = 16'hC2C2;
        exact_gap = 1;
        for (int k = 0; k < 6; k++) begin
            g = (k % 2 == 0) ? 3'b001 : 3'b100;
            exp_launch.push_back('{g, (k % 2 == 0) ? 16'hC0C0 : 16'hC2C2});
            exp_rsp.push_back('{g, (k % 2 == 0) ? 16'h5100 : 16'h5322, 1'b0});
        end
        base_rsp = n_rsp;
        remaining[0] = 3;
        remaining[2] = 3;
        req = 3'b101;
        wait_rsp(base_rsp + 6, 700, "fair");
        exact_gap = 0;
        n_cmp++; if (exp_rsp.size() != 0) begin n_bad++; $display("FAIL fair_drain: got %0d left want 0", exp_rsp.size()); end
    endtask

    task automatic test_stale_done();
        int base_rsp;
        apply_reset();
        spi_done    = 1'b1;
        spi_rd_data = 16'hDEAD;
        stale_mode  = 1;
        stub_delay  = 20;
        stub_data[0] = 16'hBEEF;
        cmd0 = 16'h0F0F;
        exp_launch.push_back('{3'b001, 16'h0F0F});
        exp_rsp.push_back('{3'b001, 16'hBEEF, 1'b0});
        base_rsp = n_rsp;
        remaining[0] = 1;
        req = 3'b001;
        wait_rsp(base_rsp + 1, 100, "stale");
        n_cmp++; if (rsp_cyc - wrt_cyc != 21) begin n_bad++; $display("FAIL stale_rsp_lat: got %0d want 21", rsp_cyc - wrt_cyc); end
        stale_mode = 0;
    endtask

    task automatic test_timeout();
        int base_rsp;
        apply_reset();
        stub_delay = 0;
        cmd2 = 16'h7777;
        exp_launch.push_back('{3'b100, 16'h7777});
        exp_rsp.push_back('{3'b100, 16'h0000, 1'b1});
        base_rsp = n_rsp;
        remaining[2] = 1;
        req = 3'b100;
        wait_rsp(base_rsp + 1, 2200, "timeout");
        n_cmp++; if (rsp_cyc - wrt_cyc != TIMEOUT + 2) begin
            n_bad++; $display("FAIL timeout_lat: got %0d want %0d", rsp_cyc - wrt_cyc, TIMEOUT + 2);
        end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL timeout_gap_gnt: got %b want 000", gnt); end
        stub_delay = 5;
        stub_data[0] = 16'h4242;
        cmd0 = 16'h0101;
        exp_launch.push_back('{3'b001, 16'h0101});
        exp_rsp.push_back('{3'b001, 16'h4242, 1'b0});
        remaining[0] = 1;
        wait_rsp(base_rsp + 2, 100, "recover");
    endtask

    task automatic test_reset_mid();
        int base_rsp, base_wrt, k;
        apply_reset();
        stub_delay = 500;
        stub_data[2] = 16'h9C9C;
        cmd2 = 16'h2222;
        exp_launch.push_back('{3'b100, 16'h2222});
        exp_launch.push_back('{3'b100, 16'h2222});
        exp_rsp.push_back('{3'b100, 16'h9C9C, 1'b0});
        base_rsp = n_rsp;
        base_wrt = n_wrt;
        remaining[2] = 1;
        req = 3'b100;
        k = 0;
        while (n_wrt == base_wrt && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        repeat (10) @(negedge clk);
        #1;
        n_cmp++; if (gnt !== 3'b100) begin n_bad++; $display("FAIL mid_gnt_before: got %b want 100", gnt); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (gnt !== 3'b000)     begin n_bad++; $display("FAIL mid_gnt: got %b want 000", gnt); end
        n_cmp++; if (rsp_vld !== 3'b000) begin n_bad++; $display("FAIL mid_rsp_vld: got %b want 000", rsp_vld); end
        n_cmp++; if (spi_wrt !== 1'b0)   begin n_bad++; $display("FAIL mid_spi_wrt: got %b want 0", spi_wrt); end
        n_cmp++; if (spi_cmd !== 16'h0)  begin n_bad++; $display("FAIL mid_spi_cmd: got %h want 0000", spi_cmd); end
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        n_cmp++; if (n_rsp != base_rsp) begin n_bad++; $display("FAIL mid_no_rsp: got %0d responses want 0", n_rsp - base_rsp); end
        wait_rsp(base_rsp + 1, 700, "regrant");
        n_cmp++; if (n_wrt - base_wrt != 2) begin n_bad++; $display("FAIL mid_wrt_count: got %0d want 2", n_wrt - base_wrt); end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            remaining[i] = 0;
            stub_data[i] = 16'h0000;
        end
        test_reset();
        test_single();
        test_simultaneous();
        test_back_to_back();
        test_stale_done();
        test_timeout();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter and sequencer that shares one 16-bit SPI master between three requesters, for example inertial sensor, A2D and an auxiliary peripheral. It takes one 16-bit command per requester and launches SPI transactions one at a time with a single-cycle `wrt` pulse. It tracks each transaction to completion through the master's level `done`, then returns the 16-bit read data to the granted requester. An enforced idle gap separates transactions, and a watchdog flags a master that never completes.

## Interface
- `GAP_CYC`, default 8: idle cycles between the end of one transaction and the next `wrt`; minimum 1.
- `TIMEOUT`, default 2047: maximum cycles spent waiting for `spi_done` before the transaction is aborted.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  3  per-requester request level; held high with its command stable until that requester's `rsp_vld` pulse.
- `cmd0`, `cmd1`, `cmd2`  in  16 each  command words for requesters 0, 1 and 2.
- `gnt`  out  3  one-hot, registered; identifies the requester owning the current transaction.
- `rsp_vld`  out  3  one-cycle pulse on the granted requester's bit when its response is ready.
- `rsp_data`  out  16  registered read data; valid in the `rsp_vld` cycle and held until the next capture.
- `rsp_err`  out  1  high together with `rsp_vld` when the transaction timed out.
- `spi_wrt`  out  1  one-cycle start pulse to the SPI master.
- `spi_cmd`  out  16  registered command to the SPI master; stable from `spi_wrt` until the next grant.
- `spi_done`  in  1  master completion level; cleared by the master the cycle after `wrt`, set when the transaction finishes.
- `spi_rd_data`  in  16  master shift-register contents; valid while `spi_done` is high.

## Operation
- **States:**
  - IDLE → LAUNCH → SETTLE → WAIT_DONE → RESP → GAP → IDLE.
  - Timeout path: WAIT_DONE → RESP with the error flag set.
- **IDLE:**
  - When `req` is non-zero, pick the first asserted bit starting at `ptr` and searching upward modulo 3.
  - Register `gnt` and copy the selected `cmdN` to `spi_cmd`, then go to LAUNCH.
  - With `req` = 0, stay in IDLE.
- **LAUNCH:** `spi_wrt` = 1 for exactly this cycle, then go to SETTLE.
- **SETTLE:**
  - One cycle; `spi_done` is ignored, because it still holds the previous transaction's level.
  - Clear the watchdog counter, then go to WAIT_DONE.
- **WAIT_DONE:**
  - Watchdog increments every cycle.
  - On `spi_done` = 1, capture `spi_rd_data` into `rsp_data` and go to RESP with error = 0.
  - When the watchdog reaches `TIMEOUT`, load `rsp_data` = 0x0000 and go to RESP with error = 1.
  - If both occur in the same cycle, `spi_done` wins and error = 0.
- **RESP:**
  - Drive `rsp_vld[gnt]` = 1 and `rsp_err` = error for one cycle.
  - Set `ptr` = (granted index + 1) mod 3, load the gap counter, then go to GAP.
- **GAP:**
  - Count `GAP_CYC` cycles, then go to IDLE.
  - `gnt` clears to 0 on entry to GAP.
- **Request changes:**
  - A `req` bit deasserted mid-transaction does not abort the transaction; `rsp_vld` still pulses.
  - `req` is sampled only in IDLE.
  - `cmdN` changes after grant have no effect, since `spi_cmd` is already latched.
- **Counter widths:** watchdog is 11 bits; gap counter is 8 bits. Parameters must fit these widths.

## Timing
- **Reset values:**
  - state = IDLE, `ptr` = 0.
  - `gnt` = 3'b000, `rsp_vld` = 3'b000, `rsp_err` = 0.
  - `rsp_data` = 0x0000, `spi_wrt` = 0, `spi_cmd` = 0x0000.
- **Reset mid-transaction:** all outputs return to their reset values asynchronously. The aborted requester gets no `rsp_vld` and must re-request.
- **Launch latency:** `req` seen in IDLE at cycle t → `gnt` and `spi_cmd` valid at t+1, `spi_wrt` high during t+1.
- **Response latency:** `spi_done` rising at cycle d → `rsp_data` and `rsp_vld` valid at d+1.
- **Back-to-back:**
  - Next `spi_wrt` comes no earlier than `rsp_vld` cycle + `GAP_CYC` + 2.
  - With `GAP_CYC` = 8, the dead time from the `rsp_vld` cycle to the next `spi_wrt` is 10 cycles.
- **Protocol invariants:** never more than one `spi_wrt` per transaction; at most one `rsp_vld` bit high in any cycle.

## Test plan
- **Single request:** `req` = 3'b010, `cmd1` = 0xA5C3, stub master echoing 0x1234 after 1100 cycles.
  - `spi_wrt` is a single pulse with `spi_cmd` = 0xA5C3 and `gnt` = 3'b010.
  - `rsp_vld[1]` pulses once with `rsp_data` = 0x1234 and `rsp_err` = 0.
- **Simultaneous requests:** `req` = 3'b111 held until each response, starting from reset.
  - Grant order is 0, 1, 2; each requester's `rsp_vld` arrives in that order with its own echoed data.
- **Fairness:** requester 0 re-asserts immediately after its response, while 2 is still pending.
  - Requester 2 is granted before 0 again; the sequence over 6 transactions is 0, 2, 0, 2, …
- **Stall timeout:** stub master never raises `spi_done`, `TIMEOUT` = 2047.
  - `rsp_vld` pulses at WAIT_DONE entry + 2047 with `rsp_err` = 1 and `rsp_data` = 0x0000.
  - The arbiter then returns to IDLE after the gap.
- **Stale done:** `spi_done` held high into the LAUNCH and SETTLE cycles, dropped one cycle after `wrt`.
  - No early `rsp_vld`; the response comes only after `spi_done` rises again.
- **Reset mid-transaction:** `rst_n` pulsed low during WAIT_DONE.
  - All outputs go to reset values immediately and no `rsp_vld` is issued.
  - With `req` = 3'b100 held, requester 2 is re-granted normally after release.
